load_store_buffer: RTL
======================

// Module: load_store_buffer
// PURPOSE
//  In-order load/store queue that receives the load/store entries the LSB reservation station issues once both
//  operands are ready. Computes effective addresses and drives a single-outstanding memory request port.
//  Broadcasts load results on the LSB CDB. Holds stores until the ROB commits them; flushes speculative entries on clear.
// PARAMETERS
//  DEPTH_LOG2  3   queue depth = 2**DEPTH_LOG2 entries
//  TAG_W       4   ROB tag width (matches `TagBus)
//  OP_W        6   opcode width (matches `OPBus)
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous active-low reset
//  rdy              in   1       global enable; no state changes when 0
//  clear            in   1       mispredict flush (synchronous)
//  in_valid         in   1       entry from RS this cycle
//  in_op            in   OP_W    LB/LH/LW/LBU/LHU/SB/SH/SW
//  in_reg1          in   32      base register value
//  in_reg2          in   32      store data
//  in_imm           in   32      sign-extended offset
//  in_rob_tag       in   TAG_W   destination ROB tag
//  lsb_is_full      out  1       to ID: stall load/store dispatch
//  rob_commit_valid in   1       ROB commits an entry this cycle
//  rob_commit_tag   in   TAG_W   tag being committed
//  mem_req_valid    out  1       memory request pending
//  mem_req_we       out  1       1 = store
//  mem_req_addr     out  32      byte address
//  mem_req_size     out  2       0 byte, 1 half, 2 word
//  mem_req_wdata    out  32      store data (low bytes used)
//  mem_done         in   1       one-cycle completion pulse
//  mem_rdata        in   32      load data (valid with mem_done, zero-extended raw bytes)
//  lsb_cdb_valid    out  1       CDB broadcast (one cycle)
//  lsb_cdb_tag      out  TAG_W   broadcast tag
//  lsb_cdb_data     out  32      load result / 0 for store-ready
// BEHAVIOUR
//  - Reset (rst_n=0, async): head=tail=count=0; FSM IDLE; all outputs 0; all entry valid/committed/announced bits 0.
//  - Push: in_valid & rdy -> write at tail, addr=in_reg1+in_imm (mod 2^32), tail++ (wraps), count++.
//    The push-when-count==DEPTH case is a protocol violation; the entry is dropped.
//  - lsb_is_full = (count >= DEPTH-1), from registered count: one slot of slack covers the RS issue register.
//  - Commit: rob_commit_valid and tag matches a valid store entry -> set committed. Loads ignore commit.
//  - CDB arbitration, one broadcast per cycle, registered:
//    - A completed load has priority.
//    - Otherwise the oldest store with announced=0 broadcasts (data 0) and sets announced; this lets the ROB mark it ready.
//  - FSM IDLE: head entry valid and (load, or store with committed=1) -> assert request next cycle; go BUSY.
//    Store addr/data latched from entry.
//  - FSM BUSY: mem_req_* held stable until mem_done.
//    - On mem_done: deassert mem_req_valid, pop head (head++, count--), go IDLE.
//    - A load produces CDB pulse next cycle with data sign/zero-extended per op (LB/LH sign, LBU/LHU zero).
//    - Earliest next request: 1 cycle after mem_done.
//  - FSM DRAIN: an in-flight load was flushed. Keep request until mem_done, discard data (no CDB), pop, go IDLE.
//  - clear (priority over push; commit in same cycle is applied first):
//    - Keep only the committed-store prefix from head; tail = head + ncommitted; count = ncommitted.
//    - BUSY on a store -> stays BUSY (store is committed). BUSY on a load -> DRAIN.
//    - Pending load CDB pulse is suppressed.
//  - Simultaneous push and pop: count unchanged; wrap of head/tail modulo DEPTH.
//  - Unaligned addresses: passed through unchanged (memory side handles them).
// STRUCTURE
//  - Opcodes, size encodings and TagBus/OPBus/DataBus widths live in shared cpu_define.v.
//  - Sub-module lsb_load_extend: combinational (op, raw 32b) -> extended 32b result.
//  - Everything else is inline: circular entry array, head/tail/count, 3-state FSM, CDB arbiter.
// TESTING
//  1 Reset mid-BUSY: deassert rst_n -> all outputs 0 asynchronously; after release, mem_req_valid stays 0 until a new push.
//  2 Push LW reg1=0x100 imm=-4 tag=3:
//    - next cycle mem_req addr=0xFC, size=2, we=0.
//    - mem_done, rdata=0x8000_00F0 -> cdb tag3 data 0x8000_00F0 one cycle later.
//  3 LB then LBU at same address, mem_rdata=0x80 -> cdb data 0xFFFF_FF80 then 0x0000_0080, in order.
//  4 Push SW tag=5 reg1=0x200 imm=8 reg2=0xDEADBEEF:
//    - cdb tag5 data 0 (announce); no mem request until rob_commit tag5.
//    - After commit: addr 0x208, we=1, wdata 0xDEADBEEF.
//  5 Fill 7 entries -> lsb_is_full=1. Push+pop same cycle keeps count; tail wraps 7->0 correctly.
//  6 Queue [committed SW, uncommitted SB, LW] with clear while the SW is BUSY:
//    - SW completes, count becomes 0 after done, no CDB for LW.
//    - Clear while a LW is BUSY -> DRAIN, mem_done yields no CDB.

Source files
------------

// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: opcodes, access sizes,
// controller states and small opcode decode helpers.
package load_store_buffer_pkg;

  localparam int OPCODE_W = 6;

  // Load/store opcodes as issued by the LSB reservation station.
  localparam logic [OPCODE_W-1:0] OP_LB  = 6'd11;
  localparam logic [OPCODE_W-1:0] OP_LH  = 6'd12;
  localparam logic [OPCODE_W-1:0] OP_LW  = 6'd13;
  localparam logic [OPCODE_W-1:0] OP_LBU = 6'd14;
  localparam logic [OPCODE_W-1:0] OP_LHU = 6'd15;
  localparam logic [OPCODE_W-1:0] OP_SB  = 6'd16;
  localparam logic [OPCODE_W-1:0] OP_SH  = 6'd17;
  localparam logic [OPCODE_W-1:0] OP_SW  = 6'd18;

  // Memory access size encodings driven on mem_req_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } lsb_state_e;

  function automatic logic is_store(input logic [OPCODE_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Combinational load result formatting: sign- or zero-extends the raw
// bytes returned by memory according to the load opcode.
module lsb_load_extend
  import load_store_buffer_pkg::*;
#(
  parameter int OP_W = OPCODE_W
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [31:0]     raw_i,
  output logic [31:0]     data_o
);

  // Select the extension that matches the access width and signedness.
  always_comb begin
    case (op_i)
      OP_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      OP_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      OP_LBU:  data_o = {24'd0, raw_i[7:0]};
      OP_LHU:  data_o = {16'd0, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: computes effective addresses on entry, issues
// one memory request at a time from the head, broadcasts load results and
// store-ready announcements on the LSB CDB, holds stores until the ROB
// commits them, and keeps only the committed-store prefix on a flush.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int TAG_W      = 4,
  parameter int OP_W       = OPCODE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_reg1,
  input  logic [31:0]      in_reg2,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_rob_tag,
  output logic             lsb_is_full,
  input  logic             rob_commit_valid,
  input  logic [TAG_W-1:0] rob_commit_tag,
  output logic             mem_req_valid,
  output logic             mem_req_we,
  output logic [31:0]      mem_req_addr,
  output logic [1:0]       mem_req_size,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             lsb_cdb_valid,
  output logic [TAG_W-1:0] lsb_cdb_tag,
  output logic [31:0]      lsb_cdb_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Entry flags (reset) and payload (not reset, qualified by valid_q).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] committed_q, committed_d;
  logic [DEPTH-1:0] announced_q, announced_d;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  ptr_t       head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d;
  lsb_state_e state_q, state_d;

  logic             req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [31:0]      req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [1:0]       req_size_q, req_size_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_data_q, cdb_data_d;

  logic        push, pop, head_store, ann_found, run;
  ptr_t        ann_idx, idx, offset;
  cnt_t        ncommit;
  logic [31:0] ext_data;

  lsb_load_extend #(.OP_W(OP_W)) u_extend (
    .op_i  (op_q[head_q]),
    .raw_i (mem_rdata),
    .data_o(ext_data)
  );

  // Next-state: commit marking, request FSM, CDB arbitration, queue pointers.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch;
    // blocking '=' here, non-blocking '<=' only in the clocked blocks.
    valid_d     = valid_q;
    committed_d = committed_q;
    announced_d = announced_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_size_d  = req_size_q;
    req_wdata_d = req_wdata_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    push        = 1'b0;
    pop         = 1'b0;
    ann_found   = 1'b0;
    ann_idx     = '0;
    idx         = '0;
    offset      = '0;
    run         = 1'b1;
    ncommit     = '0;
    head_store  = is_store(op_q[head_q]);

    if (rdy) begin
      // Commit is applied first so a same-cycle flush keeps the store.
      for (int j = 0; j < DEPTH; j++) begin
        if (rob_commit_valid && valid_q[j] && is_store(op_q[j]) &&
            tag_q[j] == rob_commit_tag) begin
          committed_d[j] = 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          // A load about to be flushed is not issued.
          if (valid_q[head_q] && (head_store ? committed_q[head_q] : !clear)) begin
            req_valid_d = 1'b1;
            req_we_d    = head_store;
            req_addr_d  = addr_q[head_q];
            req_size_d  = op_size(op_q[head_q]);
            req_wdata_d = data_q[head_q];
            state_d     = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            req_valid_d = 1'b0;
            state_d     = ST_IDLE;
            // A load finishing in the flush cycle was already discarded.
            if (req_we_q || !clear) pop = 1'b1;
            if (!req_we_q && !clear) begin
              cdb_valid_d = 1'b1;
              cdb_tag_d   = tag_q[head_q];
              cdb_data_d  = ext_data;
            end
          end else if (clear && !req_we_q) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The flushed load's entry is gone; just retire the request.
          if (mem_done) begin
            req_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Oldest not-yet-announced store gets the CDB when no load result does.
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + ptr_t'(i);
        if (!ann_found && valid_q[idx] && is_store(op_q[idx]) && !announced_q[idx]) begin
          ann_found = 1'b1;
          ann_idx   = idx;
        end
      end
      if (!cdb_valid_d && !clear && ann_found) begin
        cdb_valid_d          = 1'b1;
        cdb_tag_d            = tag_q[ann_idx];
        cdb_data_d           = '0;
        announced_d[ann_idx] = 1'b1;
      end

      if (pop) begin
        valid_d[head_q]     = 1'b0;
        committed_d[head_q] = 1'b0;
        announced_d[head_q] = 1'b0;
        head_d              = head_q + ptr_t'(1);
      end

      if (clear) begin
        // Length of the committed-store run starting at head.
        for (int i = 0; i < DEPTH; i++) begin
          idx = head_q + ptr_t'(i);
          if (run && valid_q[idx] && is_store(op_q[idx]) && committed_d[idx]) begin
            ncommit = ncommit + cnt_t'(1);
          end else begin
            run = 1'b0;
          end
        end
        for (int j = 0; j < DEPTH; j++) begin
          offset = ptr_t'(j) - head_q;
          if (cnt_t'(offset) >= ncommit) begin
            valid_d[j]     = 1'b0;
            committed_d[j] = 1'b0;
            announced_d[j] = 1'b0;
          end
        end
        tail_d  = head_q + ptr_t'(ncommit);
        count_d = ncommit - cnt_t'(pop);
      end else begin
        push = in_valid && (count_q != DEPTH_C);
        if (push) begin
          valid_d[tail_q]     = 1'b1;
          committed_d[tail_q] = 1'b0;
          announced_d[tail_q] = 1'b0;
          tail_d              = tail_q + ptr_t'(1);
        end
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Control state, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      committed_q <= '0;
      announced_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_size_q  <= '0;
      req_wdata_q <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      announced_q <= announced_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_size_q  <= req_size_d;
      req_wdata_q <= req_wdata_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  // Entry payload written at tail on push.
  // NOTE: payload array has no reset; valid_q alone says which slots hold data.
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[tail_q]   <= in_op;
      addr_q[tail_q] <= in_reg1 + in_imm;
      data_q[tail_q] <= in_reg2;
      tag_q[tail_q]  <= in_rob_tag;
    end
  end

  assign lsb_is_full   = (count_q >= DEPTH_C - cnt_t'(1));
  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_size  = req_size_q;
  assign mem_req_wdata = req_wdata_q;
  assign lsb_cdb_valid = cdb_valid_q;
  assign lsb_cdb_tag   = cdb_tag_q;
  assign lsb_cdb_data  = cdb_data_q;

endmodule
